// File: rtl/dwbuf_pkg.sv
// dwbuf_pkg: shared types and defaults for the depthwise weight buffer loaders
package dwbuf_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} dwdata_state_e;
  localparam logic [1:0] RRESP_OKAY = 2'b00;
  localparam int DW_BURST = 16;
  localparam int DW_DEPTH = 144;
endpackage

// File: rtl/dwdata_recv.sv
// dwdata_recv: paces burst requests and writes AXI read beats into the depthwise weight buffer (optional DWDATA_RRESP_CHECK_EN)
module dwdata_recv
  import dwbuf_pkg::*;
#(
  parameter int DW    = 32,
  parameter int BURST = DW_BURST,
  parameter int DEPTH = DW_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               num_bursts,
  output logic                     req_next,
  input  logic [DW-1:0]            rdata,
  input  logic                     rvalid,
  input  logic                     rlast,
  input  logic [1:0]               rresp,
  output logic                     rready,
  output logic                     buf_wr_en,
  output logic [$clog2(DEPTH)-1:0] buf_wr_addr,
  output logic [DW-1:0]            buf_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int BW = $clog2(DEPTH);
  localparam int CW = $clog2(BURST);
  dwdata_state_e state, state_d;
  logic [7:0]    nb_lat, burst_cnt;
  logic [CW-1:0] beat_cnt;
  logic [BW-1:0] wr_ptr;
  logic          hs, beat_last, eob, start_ok, resp_bad;
  assign rready    = state == RECV;
  assign req_next  = state == REQ;
  assign done      = state == DONE;
  assign busy      = state != IDLE;
  assign hs        = rready & rvalid;
  assign beat_last = beat_cnt == CW'(BURST - 1);
  assign eob       = rlast | beat_last;
  assign start_ok  = state == IDLE && start && num_bursts != 8'd0;
`ifdef DWDATA_RRESP_CHECK_EN
  assign resp_bad = rresp != RRESP_OKAY;
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp;
  assign resp_bad = 1'b0;
`endif
  // next-state decode; a burst ends on rlast or the final beat count
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = start ? (num_bursts != 8'd0 ? REQ : DONE) : IDLE;
      REQ:     state_d = RECV;
      RECV:    state_d = hs && eob ? (burst_cnt + 8'd1 == nb_lat ? DONE : REQ) : RECV;
      default: state_d = IDLE;
    endcase
  end
  // state, counters, registered buffer write and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      nb_lat      <= '0;
      burst_cnt   <= '0;
      beat_cnt    <= '0;
      wr_ptr      <= '0;
      err         <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
    end else begin
      state     <= state_d;
      buf_wr_en <= hs;
      if (hs) begin
        buf_wr_addr <= wr_ptr;
        buf_wr_data <= rdata;
      end
      if (start_ok) begin
        nb_lat    <= num_bursts;
        burst_cnt <= '0;
        beat_cnt  <= '0;
        wr_ptr    <= '0;
        err       <= 1'b0;
      end else if (hs) begin
        wr_ptr    <= wr_ptr == BW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        beat_cnt  <= eob ? '0 : beat_cnt + 1'b1;
        burst_cnt <= eob ? burst_cnt + 8'd1 : burst_cnt;
        err       <= err | (rlast != beat_last) | resp_bad;
      end
    end
  end
endmodule

// File: tb/tb_dwdata_recv.sv
// tb_dwdata_recv: randomized load scenarios checked against a beat-level reference model
module tb_dwdata_recv;
  localparam int DW = 32;
  localparam int BURST = 16;
  localparam int DEPTH = 144;
`ifdef DWDATA_RRESP_CHECK_EN
  localparam bit RESP_CHK = 1'b1;
`else
  localparam bit RESP_CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] num_bursts = '0;
  logic [DW-1:0] rdata = '0;
  logic rvalid = 1'b0, rlast = 1'b0;
  logic [1:0] rresp = 2'b00;
  logic req_next, rready, buf_wr_en, busy, done, err;
  logic [$clog2(DEPTH)-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  int n_tests = 0, n_fail = 0;
  bit m_err = 1'b0;
  int exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  dwdata_recv #(.DW(DW), .BURST(BURST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .num_bursts(num_bursts), .req_next(req_next),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rready(rready),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_next", req_next, 0);
    chk("rst_rready", rready, 0);
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_wr_addr", buf_wr_addr, 0);
    chk("rst_wr_data", buf_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  // nb bursts; burst sb has slen beats (or no rlast if nolast); beat index bad gets SLVERR;
  // mode 0: rvalid always, 1: every other cycle, 2: random; rst_at: reset after that many beats
  task automatic run_load(input int nb, input int sb, input int slen, input bit nolast,
                          input int bad, input int mode, input int rst_at);
    int b = 0, bi = 0, widx = 0, nreq = 0, ndone = 0, cyc = 0, len;
    bit acc, v;
    @(negedge clk);
    start = 1'b1;
    num_bursts = nb[7:0];
    if (nb != 0) m_err = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 3000) begin
      if (cyc == 0 && nb != 0) begin
        chk("req_latency", req_next, 1);
        chk("err_cleared", err, 0);
      end
      if (buf_wr_en) begin
        if (exp_addr_q.size() == 0) chk("spurious_write", 1, 0);
        else begin
          chk("wr_addr", buf_wr_addr, exp_addr_q.pop_front());
          chk("wr_data", buf_wr_data, exp_data_q.pop_front());
        end
      end
      nreq += int'(req_next);
      if (done) begin
        ndone++;
        chk("writes_done_with_done", exp_addr_q.size(), 0);
        chk("busy_at_done", busy, 1);
        break;
      end
      if (cyc == 3) begin
        start = 1'b1;
        num_bursts = 8'd7;
      end else start = 1'b0;
      len = (b == sb) ? slen : BURST;
      v = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : ($urandom_range(0, 99) < 60);
      rvalid = b < nb && v;
      rdata = $urandom;
      rlast = rvalid ? (bi == len - 1 && !(b == sb && nolast)) : 1'($urandom_range(0, 1));
      rresp = widx == bad ? 2'b10 : 2'b00;
      acc = rvalid && rready;
      if (acc) begin
        exp_addr_q.push_back(widx % DEPTH);
        exp_data_q.push_back(rdata);
        if (widx == bad && RESP_CHK) m_err = 1'b1;
        widx++;
        bi++;
        if (bi == len) begin
          if (len != BURST || (b == sb && nolast)) m_err = 1'b1;
          b++;
          bi = 0;
        end
        if (widx == rst_at) begin
          #2 rst = 1'b1;
          #1 chk_reset_vals();
          exp_addr_q.delete();
          exp_data_q.delete();
          m_err = 1'b0;
          rvalid = 1'b0;
          @(negedge clk);
          chk("rst_no_done", done, 0);
          chk("rst_held_idle", busy, 0);
          rst = 1'b0;
          return;
        end
      end
      cyc++;
      @(negedge clk);
    end
    rvalid = 1'b0;
    chk("done_seen", ndone, 1);
    chk("req_count", nreq, nb);
    chk("err_at_done", err, m_err);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("no_extra_write", buf_wr_en, 0);
  endtask

  initial begin
    #3 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    run_load(1, -1, BURST, 1'b0, -1, 0, -1);
    run_load(3, -1, BURST, 1'b0, -1, 1, -1);
    run_load(10, -1, BURST, 1'b0, -1, 2, -1);
    run_load(2, 1, 10, 1'b0, -1, 2, -1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    run_load(2, 0, BURST, 1'b1, -1, 2, -1);
    run_load(1, -1, BURST, 1'b0, 4, 2, -1);
    run_load(0, -1, BURST, 1'b0, -1, 0, -1);
    run_load(2, -1, BURST, 1'b0, -1, 2, 7);
    run_load(1, -1, BURST, 1'b0, -1, 0, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dwdata_recv.md
# dwdata_recv

Read-data stage for the depthwise weight loader. Sits directly downstream of the depthwise weight address generator: it paces burst requests (its `req_next` pulse drives the generator's `weight_load`), accepts the returning AXI read-data beats and writes them sequentially into the depthwise weight buffer SRAM. It reports completion and protocol errors to the layer controller.

## Interface
- `DW`, 32, read-data / buffer word width
- `BURST`, 16, beats per burst; must match the address generator's burst length
- `DEPTH`, 144, weight buffer depth in words
- `BW`, `$clog2(DEPTH)`, buffer address width (derived, not overridden)
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: one-cycle pulse, begin a load of `num_bursts` bursts
- `num_bursts` in 8: burst count, sampled on accepted `start`
- `req_next` out 1: one-cycle pulse requesting the next burst address (to `weight_load`)
- `rdata` in DW: read data
- `rvalid` in 1: read data valid
- `rlast` in 1: last beat of burst
- `rresp` in 2: read response
- `rready` out 1: read data ready
- `buf_wr_en` out 1: buffer write strobe
- `buf_wr_addr` out BW: buffer write address
- `buf_wr_data` out DW: buffer write data
- `busy` out 1: load in progress
- `done` out 1: one-cycle pulse, all bursts received
- `err` out 1: sticky protocol error

## Operation
- FSM states: IDLE, REQ, RECV, DONE.
- IDLE: `start` with `num_bursts != 0` → latch count, clear burst counter, beat counter, write pointer and `err` → REQ. `start` with `num_bursts == 0` → DONE directly (`done` pulses, no request).
- REQ: `req_next = 1` for exactly this cycle → RECV.
- RECV: `rready = 1`. Each handshake (`rvalid & rready`) writes `rdata` at the write pointer, then increments the beat counter and the write pointer.
- The write pointer wraps from `DEPTH-1` to 0.
- End of burst: accepted beat with `rlast = 1` or beat counter `== BURST-1`, whichever comes first. `err` is set if the two disagree (early or missing `rlast`).
- After end of burst: burst counter increments and the beat counter clears. If the count reaches the latched `num_bursts` → DONE; otherwise → REQ.
- DONE: `done = 1` for one cycle → IDLE.
- `busy = 1` in REQ, RECV and DONE.
- `start` outside IDLE is ignored.
- `rvalid` outside RECV is not accepted (`rready = 0`) and has no effect.

## Timing
- Reset values: `req_next = 0`, `rready = 0`, `buf_wr_en = 0`, `buf_wr_addr = 0`, `buf_wr_data = 0`, `busy = 0`, `done = 0`, `err = 0`. FSM in IDLE, all counters 0.
- Reset asserted mid-load aborts immediately. No `done` pulse is issued; buffer contents are undefined.
- `start` → `req_next`: 1 cycle (REQ entered on the next edge).
- `rready` is decoded from registered state only; no combinational path from `rvalid`.
- Buffer write is registered: a beat accepted in cycle N appears as `buf_wr_en = 1` with its address and data in cycle N+1.
- Last beat accepted in cycle N:
  - Further bursts remain: `req_next` in cycle N+1.
  - Final burst: `done` in cycle N+1, `busy` low from N+2.
  - The final buffer write coincides with `done`.
- Minimum per-burst overhead: one REQ cycle between the last beat of one burst and `rready` for the next.
- Counter widths: beat counter `$clog2(BURST)` bits; burst counter 8 bits, compared against the latched `num_bursts` (max 255 bursts).

## Configuration
- `DWDATA_RRESP_CHECK_EN` defined: any accepted beat with `rresp != 2'b00` sets `err`; the data is still written.
- Not defined: `rresp` is ignored (port kept, unused); `err` reflects only `rlast` mismatches.

## Structure
- Shared package `dwbuf_pkg`:
  - FSM state enum `dwdata_state_e` (IDLE, REQ, RECV, DONE).
  - Constant `RRESP_OKAY = 2'b00`.
  - Default `BURST` and `DEPTH` constants, shared with the address generator.
- Single module; no sub-module warranted. The wrapping write pointer is inline logic.

## Test plan
- `start`, `num_bursts = 1`, 16 beats with `rvalid` always high and `rlast` on beat 16 → one `req_next`; `buf_wr_addr` 0..15 in order with matching data; `done` one cycle after beat 16; `err = 0`.
- `num_bursts = 3`, `rvalid` toggling every other cycle → exactly 3 `req_next` pulses, 48 sequential writes at addresses 0..47, single `done`.
- `DEPTH = 20`, `num_bursts = 2` → writes at addresses 0..19, then 0..11 (wrap); `done` asserted.
- `rlast` asserted on beat 10 of a burst → burst ends after 10 writes; `err = 1` and stays 1 until the next `start`. Separately: no `rlast` on beat 16 → burst ends at beat 16, `err = 1`.
- With `DWDATA_RRESP_CHECK_EN`: `rresp = 2'b10` on beat 5 → beat still written, `err = 1`. Without the macro → `err = 0`.
- `rst` asserted after 7 beats of burst 1 of 2 → all outputs return to reset values asynchronously; no `done`. A subsequent `start` with `num_bursts = 1` completes normally from address 0.
